// File: rtl/token_classifier.sv
// Word assembler and classifier behind the tokenizer: collects characters into words, tags each
// as WORD or NUM (decimal, 0x hex, 0b binary, optional leading '-'), and emits EOL tokens.
module token_classifier #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned VALUE_WIDTH = 32,
  parameter int unsigned MAX_CHARS   = 16,
  localparam int unsigned LEN_WIDTH  = $clog2(MAX_CHARS + 1)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_en,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic                            i_data_ready,
  input  logic                            i_eol,
  input  logic                            i_wc,
  output logic                            o_next,
  output logic                            o_tok_valid,
  input  logic                            i_tok_ready,
  output logic [1:0]                      o_tok_type,
  output logic [VALUE_WIDTH-1:0]          o_tok_value,
  output logic [LEN_WIDTH-1:0]            o_tok_len,
  output logic [MAX_CHARS*DATA_WIDTH-1:0] o_tok_chars,
  output logic                            o_tok_trunc
);

  localparam logic [1:0] ST_COLLECT   = 2'd0;
  localparam logic [1:0] ST_EMIT_WORD = 2'd1;
  localparam logic [1:0] ST_EMIT_EOL  = 2'd2;

  localparam logic [1:0] TYPE_WORD = 2'd0;
  localparam logic [1:0] TYPE_NUM  = 2'd1;
  localparam logic [1:0] TYPE_EOL  = 2'd2;

  localparam logic [1:0] RADIX_DEC = 2'd0;
  localparam logic [1:0] RADIX_HEX = 2'd1;
  localparam logic [1:0] RADIX_BIN = 2'd2;

  logic [1:0]                      state_q, state_d;
  logic [MAX_CHARS*DATA_WIDTH-1:0] word_q, word_d;
  logic [LEN_WIDTH-1:0]            len_q, len_d;
  logic [VALUE_WIDTH-1:0]          acc_q, acc_d;
  logic [1:0]                      radix_q, radix_d;
  logic                            trunc_q, trunc_d;
  logic                            eol_pend_q, eol_pend_d;
  logic                            neg_q, neg_d;
  logic                            digit_q, digit_d;
  logic                            bad_q, bad_d;
  logic                            prev_ready_q, prev_ready_d;

  logic                   take;
  logic                   is_dec, is_hex_alpha, legal;
  logic [3:0]             digit;
  logic [VALUE_WIDTH-1:0] acc_scaled;
  logic                   is_num, emit_word, emit_eol;

  assign take = i_en && (state_q == ST_COLLECT) && i_data_ready && !prev_ready_q;

  assign is_dec       = (i_data >= 8'h30) && (i_data <= 8'h39);
  assign is_hex_alpha = ((i_data >= 8'h61) && (i_data <= 8'h66)) ||
                        ((i_data >= 8'h41) && (i_data <= 8'h46));
  // ASCII low nibble is the digit for 0-9 and value-9 for a-f/A-F
  assign digit        = is_dec ? i_data[3:0] : i_data[3:0] + 4'd9;

  always_comb begin
    legal      = 1'b0;
    acc_scaled = '0;
    unique case (radix_q)
      RADIX_HEX: begin
        legal      = is_dec || is_hex_alpha;
        acc_scaled = acc_q << 4;
      end
      RADIX_BIN: begin
        legal      = (i_data == 8'h30) || (i_data == 8'h31);
        acc_scaled = acc_q << 1;
      end
      default: begin
        legal      = is_dec;
        acc_scaled = (acc_q << 3) + (acc_q << 1);
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    len_d        = len_q;
    acc_d        = acc_q;
    radix_d      = radix_q;
    trunc_d      = trunc_q;
    eol_pend_d   = eol_pend_q;
    neg_d        = neg_q;
    digit_d      = digit_q;
    bad_d        = bad_q;
    prev_ready_d = i_en ? i_data_ready : prev_ready_q;

    if (i_en) begin
      unique case (state_q)
        ST_COLLECT: begin
          if (take) begin
            if (i_eol) begin
              if (len_q != '0) begin
                state_d    = ST_EMIT_WORD;
                eol_pend_d = 1'b1;
              end else begin
                state_d    = ST_EMIT_EOL;
              end
            end else if (i_wc) begin
              if (len_q != '0) state_d = ST_EMIT_WORD;
            end else begin
              if (len_q < LEN_WIDTH'(MAX_CHARS)) begin
                word_d[int'(len_q)*DATA_WIDTH +: DATA_WIDTH] = i_data;
                len_d = len_q + 1'b1;
              end else begin
                trunc_d = 1'b1;
              end
              if ((len_q == '0) && (i_data == 8'h2D)) begin
                neg_d = 1'b1;
              end else if ((len_q == LEN_WIDTH'(1)) && (word_q[7:0] == 8'h30) &&
                           ((i_data == 8'h78) || (i_data == 8'h58))) begin
                radix_d = RADIX_HEX;
                acc_d   = '0;
                digit_d = 1'b0;
              end else if ((len_q == LEN_WIDTH'(1)) && (word_q[7:0] == 8'h30) &&
                           ((i_data == 8'h62) || (i_data == 8'h42))) begin
                radix_d = RADIX_BIN;
                acc_d   = '0;
                digit_d = 1'b0;
              end else if (legal) begin
                acc_d   = acc_scaled + VALUE_WIDTH'(digit);
                digit_d = 1'b1;
              end else begin
                bad_d   = 1'b1;
              end
            end
          end
        end
        ST_EMIT_WORD: begin
          if (i_tok_ready) begin
            state_d    = eol_pend_q ? ST_EMIT_EOL : ST_COLLECT;
            word_d     = '0;
            len_d      = '0;
            acc_d      = '0;
            radix_d    = RADIX_DEC;
            trunc_d    = 1'b0;
            eol_pend_d = 1'b0;
            neg_d      = 1'b0;
            digit_d    = 1'b0;
            bad_d      = 1'b0;
          end
        end
        ST_EMIT_EOL: begin
          if (i_tok_ready) state_d = ST_COLLECT;
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_COLLECT;
      word_q       <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      radix_q      <= RADIX_DEC;
      trunc_q      <= 1'b0;
      eol_pend_q   <= 1'b0;
      neg_q        <= 1'b0;
      digit_q      <= 1'b0;
      bad_q        <= 1'b0;
      prev_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      radix_q      <= radix_d;
      trunc_q      <= trunc_d;
      eol_pend_q   <= eol_pend_d;
      neg_q        <= neg_d;
      digit_q      <= digit_d;
      bad_q        <= bad_d;
      prev_ready_q <= prev_ready_d;
    end
  end

  assign emit_word = (state_q == ST_EMIT_WORD);
  assign emit_eol  = (state_q == ST_EMIT_EOL);
  assign is_num    = digit_q && !bad_q && !trunc_q;

  assign o_next      = i_en && (state_q == ST_COLLECT);
  assign o_tok_valid = emit_word || emit_eol;
  assign o_tok_type  = emit_eol ? TYPE_EOL : ((emit_word && is_num) ? TYPE_NUM : TYPE_WORD);
  assign o_tok_value = (emit_word && is_num) ? (neg_q ? -acc_q : acc_q) : '0;
  assign o_tok_len   = emit_word ? len_q : '0;
  assign o_tok_chars = emit_word ? word_q : '0;
  assign o_tok_trunc = emit_word && trunc_q;

endmodule

// File: tb/tb_token_classifier.sv
// Scoreboard bench for token_classifier: expected tokens are queued as strings are fed,
// a monitor pops and compares every accepted token.
module tb_token_classifier;

  localparam int unsigned MC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [7:0]    data = '0;
  logic          data_ready = 1'b0;
  logic          eol = 1'b0;
  logic          wc = 1'b0;
  logic          next;
  logic          tok_valid;
  logic          tok_ready = 1'b1;
  logic [1:0]    tok_type;
  logic [31:0]   tok_value;
  logic [4:0]    tok_len;
  logic [MC*8-1:0] tok_chars;
  logic          tok_trunc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]      typ;
    logic [31:0]     value;
    logic [4:0]      len;
    logic [MC*8-1:0] chars;
    logic            trunc;
  } tok_t;

  tok_t exp_q[$];

  token_classifier #(.DATA_WIDTH(8), .VALUE_WIDTH(32), .MAX_CHARS(MC)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_data      (data),
    .i_data_ready(data_ready),
    .i_eol       (eol),
    .i_wc        (wc),
    .o_next      (next),
    .o_tok_valid (tok_valid),
    .i_tok_ready (tok_ready),
    .o_tok_type  (tok_type),
    .o_tok_value (tok_value),
    .o_tok_len   (tok_len),
    .o_tok_chars (tok_chars),
    .o_tok_trunc (tok_trunc)
  );

  always #5 clk = ~clk;

  function automatic tok_t make_tok(input logic [1:0] typ, input logic [31:0] value,
                                    input string text, input logic trunc);
    tok_t t;
    int n;
    n = (text.len() > MC) ? MC : text.len();
    t.typ   = typ;
    t.value = value;
    t.len   = 5'(n);
    t.chars = '0;
    t.trunc = trunc;
    for (int i = 0; i < n; i++) t.chars[i*8 +: 8] = text[i];
    return t;
  endfunction

  task automatic check_tok(input string name, input tok_t e);
    checks++;
    if (tok_type !== e.typ || tok_value !== e.value || tok_len !== e.len ||
        tok_chars !== e.chars || tok_trunc !== e.trunc) begin
      failures++;
      $display("FAIL %s: got type=%0d value=%h len=%0d trunc=%0b chars=%h, want type=%0d value=%h len=%0d trunc=%0b chars=%h",
               name, tok_type, tok_value, tok_len, tok_trunc, tok_chars,
               e.typ, e.value, e.len, e.trunc, e.chars);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0b want %0b", name, got, want);
    end
  endtask

  // Monitor: every handshake pops one expected token
  always begin
    @(negedge clk);
    #1;
    if (!rst && en && tok_valid && tok_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_token: got type=%0d value=%h len=%0d, want none",
                 tok_type, tok_value, tok_len);
      end else begin
        check_tok("token", exp_q.pop_front());
      end
    end
  end

  task automatic send_char(input byte c);
    int n;
    n = 0;
    @(negedge clk);
    while (!next && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!next) begin
      checks++;
      failures++;
      $display("FAIL next_timeout: got o_next=0 want 1");
    end
    data       = c;
    wc         = (c == 8'h20);
    eol        = (c == 8'h0a);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d tokens outstanding want 0", exp_q.size());
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (!tok_valid && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_bit(name, tok_valid, 1'b1);
  endtask

  initial begin
    tok_t zero_tok;
    tok_t hold_tok;
    zero_tok = make_tok(2'd0, 32'd0, "", 1'b0);

    // Reset state with block disabled
    repeat (3) @(negedge clk);
    #1;
    check_bit("reset_valid", tok_valid, 1'b0);
    check_bit("reset_next_en0", next, 1'b0);
    check_tok("reset_outputs", zero_tok);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_bit("next_en0", next, 1'b0);
    en = 1'b1;
    #1;
    check_bit("next_en1", next, 1'b1);

    // 1: DUP 12\n
    exp_q.push_back(make_tok(2'd0, 32'd0, "DUP", 1'b0));
    exp_q.push_back(make_tok(2'd1, 32'd12, "12", 1'b0));
    exp_q.push_back(make_tok(2'd2, 32'd0, "", 1'b0));
    send_str("DUP 12\n");
    drain();

    // 2: hex, binary, negative decimal
    exp_q.push_back(make_tok(2'd1, 32'd31, "0x1F", 1'b0));
    exp_q.push_back(make_tok(2'd1, 32'd5, "0b101", 1'b0));
    exp_q.push_back(make_tok(2'd1, 32'hFFFF_FFF9, "-7", 1'b0));
    send_str("0x1F 0b101 -7 ");
    drain();

    // 3: malformed literals fall back to WORD
    exp_q.push_back(make_tok(2'd0, 32'd0, "0x", 1'b0));
    exp_q.push_back(make_tok(2'd0, 32'd0, "0xG", 1'b0));
    exp_q.push_back(make_tok(2'd0, 32'd0, "1a", 1'b0));
    exp_q.push_back(make_tok(2'd0, 32'd0, "-", 1'b0));
    exp_q.push_back(make_tok(2'd2, 32'd0, "", 1'b0));
    send_str("0x 0xG 1a -\n");
    drain();

    // 4: leading separators and blank line
    exp_q.push_back(make_tok(2'd0, 32'd0, "A", 1'b0));
    exp_q.push_back(make_tok(2'd2, 32'd0, "", 1'b0));
    exp_q.push_back(make_tok(2'd2, 32'd0, "", 1'b0));
    send_str("  A\n\n");
    drain();

    // 5: overlong word truncated; digits-only overflow word still WORD
    exp_q.push_back(make_tok(2'd0, 32'd0, "ABCDEFGHIJKLMNOPQRST", 1'b1));
    exp_q.push_back(make_tok(2'd0, 32'd0, "12345678901234567", 1'b1));
    send_str("ABCDEFGHIJKLMNOPQRST 12345678901234567 ");
    drain();

    // 6: backpressure hold
    tok_ready = 1'b0;
    hold_tok  = make_tok(2'd0, 32'd0, "HOLD", 1'b0);
    exp_q.push_back(hold_tok);
    send_str("HOLD ");
    wait_valid("hold_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check_bit("hold_next", next, 1'b0);
      check_bit("hold_valid_stable", tok_valid, 1'b1);
      check_tok("hold_stable", hold_tok);
    end
    @(negedge clk);
    tok_ready = 1'b1;
    drain();

    // Reset with a pending token: discarded asynchronously
    tok_ready = 1'b0;
    send_str("RST ");
    wait_valid("pend_valid");
    #2;
    rst = 1'b1;
    #1;
    check_bit("rst_pend_valid", tok_valid, 1'b0);
    check_tok("rst_pend_outputs", zero_tok);
    @(negedge clk);
    rst = 1'b0;
    tok_ready = 1'b1;

    // Reset mid-word: partial "AB" must not prefix the next word
    send_str("AB");
    #3;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_bit("rst_mid_valid", tok_valid, 1'b0);
    check_tok("rst_mid_outputs", zero_tok);
    rst = 1'b0;
    exp_q.push_back(make_tok(2'd1, 32'd9, "9", 1'b0));
    exp_q.push_back(make_tok(2'd2, 32'd0, "", 1'b0));
    send_str("9\n");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
